ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader_if.sv | 29 ++
 rtl/ram_stream_reader.sv | 122 ++++++++++++
 tb/tb_ram_stream_reader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_if.sv
// Command, RAM read port and output stream of the RAM stream reader.
// The master modport is the reader itself; slave is the command/RAM/sink side.
interface ram_stream_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   num_words;
    logic                  busy;
    logic                  done;
    logic                  mem_read_req;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        input  start, base_addr, num_words, mem_read_data, m_ready,
        output busy, done, mem_read_req, mem_read_addr, m_valid, m_data, m_last
    );

    modport slave (
        output start, base_addr, num_words, mem_read_data, m_ready,
        input  busy, done, mem_read_req, mem_read_addr, m_valid, m_data, m_last
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Streams num_words consecutive words out of a latency-1 registered RAM into a
// valid/ready stream, buffering returns in a 2-entry FIFO so reads never overrun it.
module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    ram_stream_reader_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic                  r_fifo_last [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_final_read;
    logic                  w_head_last;
    logic [2:0]            w_occupancy;

    assign w_push       = r_inflight;
    assign w_pop        = (r_count != 2'd0) && bus.m_ready;
    assign w_final_read = (r_remaining == (ADDR_WIDTH+1)'(1));
    assign w_head_last  = r_fifo_last[r_rd_ptr];
    // Words already buffered plus the one in flight, less the one leaving now.
    assign w_occupancy  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.num_words != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                if (w_occupancy < 3'd2) begin
                    w_issue = 1'b1;
                    if (w_final_read) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && w_head_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control state; clearing r_inflight on reset drops any read still returning.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_final_read;
            if (r_state == S_IDLE && bus.start) begin
                r_addr      <= bus.base_addr;
                r_remaining <= bus.num_words;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
            end
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // FIFO storage carries no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= bus.mem_read_data;
            r_fifo_last[r_wr_ptr] <= r_inflight_last;
        end
    end

    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = (r_state == S_DONE);
    assign bus.mem_read_req  = w_issue;
    assign bus.mem_read_addr = r_addr;
    assign bus.m_valid       = (r_count != 2'd0);
    assign bus.m_data        = bus.m_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign bus.m_last        = bus.m_valid && w_head_last;
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a latency-1 RAM model holding mem[i]=i.
module tb_ram_stream_reader;
    localparam int DW = 8;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [DW-1:0] mem [1<<AW];
    int n_checks = 0;
    int n_errors = 0;
    int addr_q[$];
    int data_q[$];
    int last_q[$];
    int issued = 0;
    int popped = 0;
    int max_out = 0;

    always @(posedge clk) begin
        if (bus.mem_read_req) bus.mem_read_data <= mem[bus.mem_read_addr];
    end

    always @(negedge clk) begin
        if (bus.mem_read_req) begin
            addr_q.push_back(int'(bus.mem_read_addr));
            issued++;
        end
        if (bus.m_valid && bus.m_ready) begin
            data_q.push_back(int'(bus.m_data));
            last_q.push_back(int'(bus.m_last));
            popped++;
        end
        if (issued - popped > max_out) max_out = issued - popped;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        addr_q.delete();
        data_q.delete();
        last_q.delete();
        issued  = 0;
        popped  = 0;
        max_out = 0;
    endtask

    task automatic go(input int base, input int num);
        bus.start     = 1'b1;
        bus.base_addr = AW'(base);
        bus.num_words = (AW+1)'(num);
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (bus.done !== 1'b1 && k < bound) begin
            step();
            k++;
        end
        chk(tag, bus.done, 1);
    endtask

    task automatic check_stream(input string tag, input int base, input int num);
        chk({tag, "_count"}, data_q.size(), num);
        for (int i = 0; i < num && i < data_q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), data_q[i], (base + i) % 256);
            chk($sformatf("%s_last%0d", tag, i), last_q[i], (i == num - 1) ? 1 : 0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_req"}, bus.mem_read_req, 0);
        chk({tag, "_valid"}, bus.m_valid, 0);
        chk({tag, "_last"}, bus.m_last, 0);
        chk({tag, "_addr"}, bus.mem_read_addr, 0);
        chk({tag, "_data"}, bus.m_data, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;
        bus.m_ready   = 1'b0;

        step();
        step();
        check_idle_outputs("reset");
        reset_n = 1'b1;
        step();

        // base 5, 4 words, sink always ready: data on cycles 3..6, done on 7
        clear_mon();
        bus.m_ready = 1'b1;
        go(5, 4);
        chk("t1_c1_busy", bus.busy, 1);
        chk("t1_c1_req", bus.mem_read_req, 1);
        chk("t1_c1_addr", bus.mem_read_addr, 5);
        chk("t1_c1_valid", bus.m_valid, 0);
        step();
        chk("t1_c2_valid", bus.m_valid, 0);
        chk("t1_c2_addr", bus.mem_read_addr, 6);
        step();
        chk("t1_c3_valid", bus.m_valid, 1);
        chk("t1_c3_data", bus.m_data, 5);
        chk("t1_c3_last", bus.m_last, 0);
        step();
        chk("t1_c4_data", bus.m_data, 6);
        step();
        chk("t1_c5_data", bus.m_data, 7);
        chk("t1_c5_req", bus.mem_read_req, 0);
        step();
        chk("t1_c6_data", bus.m_data, 8);
        chk("t1_c6_last", bus.m_last, 1);
        chk("t1_c6_done", bus.done, 0);
        step();
        chk("t1_c7_done", bus.done, 1);
        chk("t1_c7_valid", bus.m_valid, 0);
        step();
        chk("t1_c8_done", bus.done, 0);
        chk("t1_c8_busy", bus.busy, 0);

        // address wrap at the top of the RAM
        clear_mon();
        go(1022, 4);
        wait_done("t2_done", 20);
        chk("t2_naddr", addr_q.size(), 4);
        if (addr_q.size() == 4) begin
            chk("t2_addr0", addr_q[0], 1022);
            chk("t2_addr1", addr_q[1], 1023);
            chk("t2_addr2", addr_q[2], 0);
            chk("t2_addr3", addr_q[3], 1);
        end
        check_stream("t2", 1022, 4);
        step();

        // backpressure: sink stalls 5 cycles after first m_valid
        clear_mon();
        bus.m_ready = 1'b0;
        go(20, 3);
        step();
        step();
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("t3_hold_valid%0d", j), bus.m_valid, 1);
            chk($sformatf("t3_hold_data%0d", j), bus.m_data, 20);
            step();
        end
        chk("t3_outstanding_during_stall", max_out, 2);
        bus.m_ready = 1'b1;
        wait_done("t3_done", 30);
        check_stream("t3", 20, 3);
        chk("t3_naddr", addr_q.size(), 3);
        chk("t3_max_outstanding_le2", (max_out <= 2) ? 1 : 0, 1);
        step();

        // zero-length command
        clear_mon();
        go(7, 0);
        chk("t4_c1_done", bus.done, 1);
        chk("t4_c1_busy", bus.busy, 1);
        chk("t4_c1_req", bus.mem_read_req, 0);
        chk("t4_c1_valid", bus.m_valid, 0);
        step();
        chk("t4_c2_done", bus.done, 0);
        chk("t4_c2_busy", bus.busy, 0);
        step();
        chk("t4_nreads", addr_q.size(), 0);
        chk("t4_nwords", data_q.size(), 0);

        // start while busy is ignored, and a start during DONE is lost
        clear_mon();
        go(40, 2);
        bus.start     = 1'b1;
        bus.base_addr = AW'(100);
        bus.num_words = (AW+1)'(5);
        step();
        bus.start = 1'b0;
        wait_done("t5_done", 20);
        bus.start     = 1'b1;
        bus.base_addr = AW'(60);
        bus.num_words = (AW+1)'(1);
        step();
        bus.start = 1'b0;
        chk("t5_start_in_done_busy", bus.busy, 0);
        chk("t5_start_in_done_req", bus.mem_read_req, 0);
        step();
        chk("t5_naddr", addr_q.size(), 2);
        check_stream("t5", 40, 2);

        // reset in the middle of an 8-word read, then a fresh command
        clear_mon();
        go(0, 8);
        step();
        step();
        reset_n = 1'b0;
        step();
        check_idle_outputs("t6_rst");
        reset_n = 1'b1;
        step();
        chk("t6_stale_valid", bus.m_valid, 0);
        chk("t6_stale_busy", bus.busy, 0);
        clear_mon();
        go(100, 2);
        wait_done("t6_done", 20);
        check_stream("t6", 100, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
